// File: rtl/vram_arbiter_if.sv
// Bus bundle for the VRAM arbiter: video fetch port, CPU bus, and the RAM read/write ports.
// The arbiter connects to the slave modport. The environment connects to the master modport.
interface vram_arbiter_if #(
  parameter int AW = 14
);
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_rvalid;
  logic [31:0]   vid_rdata;

  logic          sel;
  logic [3:0]    wstrb;
  logic [23:0]   addr;
  logic [31:0]   wdata;
  logic          ready;
  logic [31:0]   rdata;
  logic [15:0]   max_wait;

  logic          ram_ren;
  logic [AW-1:0] ram_raddr;
  logic          ram_wen;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [3:0]    ram_wstrb;
  logic [31:0]   ram_rdata;

  modport master (
    output vid_req, vid_addr, sel, wstrb, addr, wdata, ram_rdata,
    input  vid_rvalid, vid_rdata, ready, rdata, max_wait,
    input  ram_ren, ram_raddr, ram_wen, ram_waddr, ram_wdata, ram_wstrb
  );

  modport slave (
    input  vid_req, vid_addr, sel, wstrb, addr, wdata, ram_rdata,
    output vid_rvalid, vid_rdata, ready, rdata, max_wait,
    output ram_ren, ram_raddr, ram_wen, ram_waddr, ram_wdata, ram_wstrb
  );
endinterface

// File: rtl/vram_arbiter.sv
// Shares one read-first RAM between a fixed-latency video fetcher and a CPU bus.
// Video always owns the read port. CPU writes use the independent write port.
module vram_arbiter #(
  parameter int AW = 14
) (
  input logic          clk,
  input logic          resetn,
  vram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_PEND = 3'd1,
    RD_WAIT = 3'd2,
    DONE    = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t        state_r;
  logic          ready_r;
  logic          vid_rvalid_r;
  logic          ram_ren_r;
  logic          owner_cpu_r;
  logic          ram_wen_r;
  logic [AW-1:0] ram_raddr_r;
  logic [AW-1:0] ram_waddr_r;
  logic [31:0]   ram_wdata_r;
  logic [3:0]    ram_wstrb_r;
  logic [31:0]   rdata_r;
  logic [15:0]   wait_cnt_r;
  logic [15:0]   max_wait_r;

  logic [AW-1:0] cpu_word_s;
  logic          cpu_write_s;
  logic          unused_s;

  // Upper address bits are dropped, so out-of-range CPU addresses wrap modulo the RAM size.
  assign cpu_word_s  = bus.addr[AW+1:2];
  assign cpu_write_s = (bus.wstrb != 4'h0);
  assign unused_s    = ^{bus.addr[23:AW+2], bus.addr[1:0]};

  // Read-port arbitration, video return pipeline and CPU transfer FSM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= IDLE;
      ready_r      <= 1'b0;
      vid_rvalid_r <= 1'b0;
      ram_ren_r    <= 1'b0;
      owner_cpu_r  <= 1'b0;
      ram_wen_r    <= 1'b0;
      ram_raddr_r  <= {AW{1'b0}};
      ram_waddr_r  <= {AW{1'b0}};
      ram_wdata_r  <= 32'h0000_0000;
      ram_wstrb_r  <= 4'h0;
      rdata_r      <= 32'h0000_0000;
      wait_cnt_r   <= 16'h0000;
      max_wait_r   <= 16'h0000;
    end else begin
      ready_r      <= 1'b0;
      ram_wen_r    <= 1'b0;
      ram_ren_r    <= 1'b0;
      // The owner tag travels with the read so CPU data never raises vid_rvalid.
      vid_rvalid_r <= ram_ren_r & ~owner_cpu_r;

      if (bus.vid_req) begin
        ram_ren_r   <= 1'b1;
        ram_raddr_r <= bus.vid_addr;
        owner_cpu_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (bus.sel) begin
            if (cpu_write_s) begin
              ram_wen_r   <= 1'b1;
              ram_waddr_r <= cpu_word_s;
              ram_wdata_r <= bus.wdata;
              ram_wstrb_r <= bus.wstrb;
              ready_r     <= 1'b1;
              state_r     <= HOLD;
            end else begin
              wait_cnt_r  <= 16'h0000;
              state_r     <= RD_PEND;
            end
          end
        end
        RD_PEND: begin
          if (!bus.sel) begin
            state_r <= IDLE;
          end else if (!bus.vid_req) begin
            ram_ren_r   <= 1'b1;
            ram_raddr_r <= cpu_word_s;
            owner_cpu_r <= 1'b1;
            state_r     <= RD_WAIT;
          end else if (wait_cnt_r != 16'hFFFF) begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        RD_WAIT: begin
          state_r <= DONE;
        end
        // RAM data for the CPU read is on ram_rdata during this state.
        DONE: begin
          rdata_r <= bus.ram_rdata;
          ready_r <= 1'b1;
          if (wait_cnt_r > max_wait_r) begin
            max_wait_r <= wait_cnt_r;
          end
          state_r <= HOLD;
        end
        HOLD: begin
          if (!bus.sel) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready      = ready_r;
  assign bus.rdata      = rdata_r;
  assign bus.max_wait   = max_wait_r;
  assign bus.vid_rvalid = vid_rvalid_r;
  assign bus.vid_rdata  = bus.ram_rdata;
  assign bus.ram_ren    = ram_ren_r;
  assign bus.ram_raddr  = ram_raddr_r;
  assign bus.ram_wen    = ram_wen_r;
  assign bus.ram_waddr  = ram_waddr_r;
  assign bus.ram_wdata  = ram_wdata_r;
  assign bus.ram_wstrb  = ram_wstrb_r;

endmodule
